// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS execute stage.
// ALU opcodes and forwarding-select values.
package mips_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/alu.sv
// Combinational ALU: add, sub, and, or, signed slt.
// Unknown opcodes produce zero.
module alu
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_ctrl,
  output logic [WIDTH-1:0] o_y
);

  logic w_lt;

  assign w_lt = $signed(i_a) < $signed(i_b);

  always_comb begin
    o_y = '0;
    case (i_ctrl)
      ALU_ADD: o_y = i_a + i_b;
      ALU_SUB: o_y = i_a - i_b;
      ALU_AND: o_y = i_a & i_b;
      ALU_OR:  o_y = i_a | i_b;
      ALU_SLT: o_y = {{(WIDTH-1){1'b0}}, w_lt};
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// MIPS execute stage: ID/EX register, forwarding muxes,
// ALU and EX/MEM register.
module execute_stage
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int REG_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FlushE,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             MemWriteD,
  input  logic [2:0]       ALUControlD,
  input  logic             ALUSrcD,
  input  logic             RegDstD,
  input  logic [WIDTH-1:0] RD1D,
  input  logic [WIDTH-1:0] RD2D,
  input  logic [REG_W-1:0] RsD,
  input  logic [REG_W-1:0] RtD,
  input  logic [REG_W-1:0] RdD,
  input  logic [WIDTH-1:0] SignImmD,
  input  logic [1:0]       ForwardAE,
  input  logic [1:0]       ForwardBE,
  input  logic [WIDTH-1:0] ResultW,
  output logic [REG_W-1:0] RsE,
  output logic [REG_W-1:0] RtE,
  output logic [REG_W-1:0] WriteRegE,
  output logic             RegWriteE,
  output logic             MemtoRegE,
  output logic             RegWriteM,
  output logic             MemtoRegM,
  output logic             MemWriteM,
  output logic [WIDTH-1:0] ALUOutM,
  output logic [WIDTH-1:0] WriteDataM,
  output logic [REG_W-1:0] WriteRegM
);

  typedef struct packed {
    logic             regw;
    logic             memtoreg;
    logic             memw;
    logic [2:0]       aluctl;
    logic             alusrc;
    logic             regdst;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic [WIDTH-1:0] imm;
  } id_ex_t;

  typedef struct packed {
    logic             regw;
    logic             memtoreg;
    logic             memw;
    logic [WIDTH-1:0] alu;
    logic [WIDTH-1:0] wd;
    logic [REG_W-1:0] wreg;
  } ex_mem_t;

  id_ex_t     r_ex;
  ex_mem_t    r_mem;
  id_ex_t     w_d;
  ex_mem_t    w_m;
  logic [WIDTH-1:0] w_srca;
  logic [WIDTH-1:0] w_fwdb;
  logic [WIDTH-1:0] w_srcb;
  logic [WIDTH-1:0] w_alu;
  logic [REG_W-1:0] w_wreg;

  assign w_d = '{
    regw:     RegWriteD,
    memtoreg: MemtoRegD,
    memw:     MemWriteD,
    aluctl:   ALUControlD,
    alusrc:   ALUSrcD,
    regdst:   RegDstD,
    rd1:      RD1D,
    rd2:      RD2D,
    rs:       RsD,
    rt:       RtD,
    rd:       RdD,
    imm:      SignImmD
  };

  // ALUOutM forwarding taps the local EX/MEM register directly
  always_comb begin
    w_srca = r_ex.rd1;
    case (ForwardAE)
      FWD_WB:  w_srca = ResultW;
      FWD_MEM: w_srca = r_mem.alu;
      default: w_srca = r_ex.rd1;
    endcase
  end

  always_comb begin
    w_fwdb = r_ex.rd2;
    case (ForwardBE)
      FWD_WB:  w_fwdb = ResultW;
      FWD_MEM: w_fwdb = r_mem.alu;
      default: w_fwdb = r_ex.rd2;
    endcase
  end

  assign w_srcb = r_ex.alusrc ? r_ex.imm : w_fwdb;
  assign w_wreg = r_ex.regdst ? r_ex.rd : r_ex.rt;

  alu #(.WIDTH(WIDTH)) u_alu (
    .i_a    (w_srca),
    .i_b    (w_srcb),
    .i_ctrl (r_ex.aluctl),
    .o_y    (w_alu)
  );

  assign w_m = '{
    regw:     r_ex.regw,
    memtoreg: r_ex.memtoreg,
    memw:     r_ex.memw,
    alu:      w_alu,
    wd:       w_fwdb,
    wreg:     w_wreg
  };

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_ex  <= '0;
      r_mem <= '0;
    end else begin
      r_ex  <= FlushE ? '0 : w_d;
      r_mem <= w_m;
    end
  end

  assign RsE        = r_ex.rs;
  assign RtE        = r_ex.rt;
  assign WriteRegE  = w_wreg;
  assign RegWriteE  = r_ex.regw;
  assign MemtoRegE  = r_ex.memtoreg;
  assign RegWriteM  = r_mem.regw;
  assign MemtoRegM  = r_mem.memtoreg;
  assign MemWriteM  = r_mem.memw;
  assign ALUOutM    = r_mem.alu;
  assign WriteDataM = r_mem.wd;
  assign WriteRegM  = r_mem.wreg;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: expected M results are
// queued at issue and popped when the instruction reaches EX/MEM.
module tb_execute_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        FlushE = 1'b0;
  logic        RegWriteD = 1'b0;
  logic        MemtoRegD = 1'b0;
  logic        MemWriteD = 1'b0;
  logic [2:0]  ALUControlD = 3'b000;
  logic        ALUSrcD = 1'b0;
  logic        RegDstD = 1'b0;
  logic [31:0] RD1D = '0;
  logic [31:0] RD2D = '0;
  logic [4:0]  RsD = '0;
  logic [4:0]  RtD = '0;
  logic [4:0]  RdD = '0;
  logic [31:0] SignImmD = '0;
  logic [1:0]  ForwardAE = 2'b00;
  logic [1:0]  ForwardBE = 2'b00;
  logic [31:0] ResultW = '0;
  logic [4:0]  RsE, RtE, WriteRegE;
  logic        RegWriteE, MemtoRegE;
  logic        RegWriteM, MemtoRegM, MemWriteM;
  logic [31:0] ALUOutM, WriteDataM;
  logic [4:0]  WriteRegM;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  wreg;
    logic        regw;
    logic        memw;
  } exp_t;

  exp_t sb[$];

  execute_stage #(.WIDTH(32), .REG_W(5)) dut (
    .CLK(CLK), .RST(RST), .FlushE(FlushE),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD),
    .MemWriteD(MemWriteD), .ALUControlD(ALUControlD),
    .ALUSrcD(ALUSrcD), .RegDstD(RegDstD),
    .RD1D(RD1D), .RD2D(RD2D), .RsD(RsD), .RtD(RtD),
    .RdD(RdD), .SignImmD(SignImmD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ResultW(ResultW), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .RegWriteE(RegWriteE),
    .MemtoRegE(MemtoRegE), .RegWriteM(RegWriteM),
    .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
    .WriteRegM(WriteRegM)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] ref_alu(
    input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    if (c == 3'b010) return a + b;
    if (c == 3'b110) return a - b;
    if (c == 3'b000) return a & b;
    if (c == 3'b001) return a | b;
    if (c == 3'b111) return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    return 32'd0;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_d(
    input logic regw, input logic memw,
    input logic [2:0] ctl, input logic alusrc, input logic regdst,
    input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
    input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    RegWriteD = regw;
    MemtoRegD = 1'b0;
    MemWriteD = memw;
    ALUControlD = ctl;
    ALUSrcD = alusrc;
    RegDstD = regdst;
    RD1D = a;
    RD2D = b;
    SignImmD = imm;
    RsD = rs;
    RtD = rt;
    RdD = rd;
  endtask

  task automatic drive_nop();
    drive_d(0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    exp_t e;
    RST = 1'b0;
    drive_d(1, 1, 3'b010, 0, 1, 32'h11, 32'h22, 0, 1, 2, 3);
    step();
    step();
    checks++;
    if (RegWriteM !== 1'b0) begin
      errors++;
      $display("FAIL reset_regwm got=%b exp=0", RegWriteM);
    end
    checks++;
    if (ALUOutM !== 32'h0) begin
      errors++;
      $display("FAIL reset_aluout got=%h exp=0", ALUOutM);
    end
    checks++;
    if (WriteRegE !== 5'd0) begin
      errors++;
      $display("FAIL reset_wrege got=%0d exp=0", WriteRegE);
    end
    checks++;
    if (RsE !== 5'd0 || RegWriteE !== 1'b0) begin
      errors++;
      $display("FAIL reset_e got=rs%0d rw%b exp=0", RsE, RegWriteE);
    end
    drive_nop();
    @(negedge CLK);
    RST = 1'b1;
    step();
    e = '{alu: 0, wd: 0, wreg: 0, regw: 0, memw: 0};
    sb.delete();
  endtask

  task automatic test_add();
    exp_t e;
    drive_d(1, 0, 3'b010, 0, 1, 32'd5, 32'd7, 0, 5'd2, 5'd9, 5'd3);
    sb.push_back('{alu: ref_alu(3'b010, 5, 7), wd: 32'd7,
                   wreg: 5'd3, regw: 1'b1, memw: 1'b0});
    step();
    drive_nop();
    checks++;
    if (RsE !== 5'd2 || RtE !== 5'd9) begin
      errors++;
      $display("FAIL add_rs_rt got=%0d/%0d exp=2/9", RsE, RtE);
    end
    checks++;
    if (WriteRegE !== 5'd3) begin
      errors++;
      $display("FAIL add_wrege got=%0d exp=3", WriteRegE);
    end
    checks++;
    if (RegWriteE !== 1'b1) begin
      errors++;
      $display("FAIL add_regwe got=%b exp=1", RegWriteE);
    end
    step();
    e = sb.pop_front();
    checks++;
    if (ALUOutM !== e.alu) begin
      errors++;
      $display("FAIL add_aluout got=%0d exp=%0d", ALUOutM, e.alu);
    end
    checks++;
    if (WriteRegM !== e.wreg || RegWriteM !== e.regw) begin
      errors++;
      $display("FAIL add_wreg got=%0d/%b exp=%0d/%b",
               WriteRegM, RegWriteM, e.wreg, e.regw);
    end
    checks++;
    if (WriteDataM !== e.wd) begin
      errors++;
      $display("FAIL add_wdata got=%0d exp=%0d", WriteDataM, e.wd);
    end
  endtask

  task automatic test_sub_slt();
    logic [2:0]  ctl [4];
    logic [31:0] a [4];
    logic [31:0] b [4];
    logic [31:0] want [4];
    exp_t e;
    ctl = '{3'b110, 3'b111, 3'b111, 3'b001};
    a = '{32'h1, 32'h1, 32'h80000000, 32'hF0};
    b = '{32'h2, 32'h2, 32'h1, 32'h0F};
    want = '{32'hFFFFFFFF, 32'h1, 32'h1, 32'hFF};
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        drive_d(1, 0, ctl[i], 0, 0, a[i], b[i], 0, 0, 5'(i + 1), 0);
        sb.push_back('{alu: ref_alu(ctl[i], a[i], b[i]), wd: b[i],
                       wreg: 5'(i + 1), regw: 1'b1, memw: 1'b0});
      end else begin
        drive_nop();
      end
      step();
      if (i >= 1 && i <= 4) begin
        e = sb.pop_front();
        checks++;
        if (ALUOutM !== e.alu || ALUOutM !== want[i-1]) begin
          errors++;
          $display("FAIL op%0d_aluout got=%h exp=%h", i - 1, ALUOutM, want[i-1]);
        end
        checks++;
        if (WriteRegM !== e.wreg) begin
          errors++;
          $display("FAIL op%0d_wreg got=%0d exp=%0d", i - 1, WriteRegM, e.wreg);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    drive_d(1, 0, 3'b010, 0, 1, 32'd4, 32'd5, 0, 0, 0, 5'd4);
    sb.push_back('{alu: 32'd9, wd: 32'd5, wreg: 5'd4, regw: 1, memw: 0});
    step();
    drive_d(1, 0, 3'b010, 1, 1, 32'd0, 32'd0, 32'd1, 5'd4, 0, 5'd5);
    sb.push_back('{alu: 32'd10, wd: 32'd0, wreg: 5'd5, regw: 1, memw: 0});
    step();
    ForwardAE = 2'b10;
    drive_nop();
    e = sb.pop_front();
    checks++;
    if (ALUOutM !== e.alu) begin
      errors++;
      $display("FAIL b2b_first got=%0d exp=%0d", ALUOutM, e.alu);
    end
    step();
    ForwardAE = 2'b00;
    e = sb.pop_front();
    checks++;
    if (ALUOutM !== e.alu || WriteRegM !== e.wreg) begin
      errors++;
      $display("FAIL b2b_fwd got=%0d/r%0d exp=%0d/r%0d",
               ALUOutM, WriteRegM, e.alu, e.wreg);
    end
  endtask

  task automatic test_flush();
    exp_t e;
    drive_d(1, 0, 3'b001, 0, 1, 32'h30, 32'h0C, 0, 0, 0, 5'd7);
    sb.push_back('{alu: 32'h3C, wd: 32'h0C, wreg: 5'd7, regw: 1, memw: 0});
    step();
    FlushE = 1'b1;
    drive_d(1, 1, 3'b010, 0, 1, 32'h5, 32'h6, 0, 5'd1, 5'd2, 5'd8);
    sb.push_back('{alu: 32'h0, wd: 32'h0, wreg: 5'd0, regw: 0, memw: 0});
    step();
    FlushE = 1'b0;
    drive_nop();
    checks++;
    if (RegWriteE !== 1'b0 || MemtoRegE !== 1'b0) begin
      errors++;
      $display("FAIL flush_e got=%b%b exp=00", RegWriteE, MemtoRegE);
    end
    checks++;
    if (WriteRegE !== 5'd0 || RsE !== 5'd0) begin
      errors++;
      $display("FAIL flush_e_idx got=%0d/%0d exp=0/0", WriteRegE, RsE);
    end
    e = sb.pop_front();
    checks++;
    if (ALUOutM !== e.alu || RegWriteM !== e.regw) begin
      errors++;
      $display("FAIL flush_keep_m got=%h/%b exp=%h/%b",
               ALUOutM, RegWriteM, e.alu, e.regw);
    end
    step();
    e = sb.pop_front();
    checks++;
    if (RegWriteM !== e.regw || MemWriteM !== e.memw) begin
      errors++;
      $display("FAIL flush_m_ctrl got=%b%b exp=00", RegWriteM, MemWriteM);
    end
    checks++;
    if (ALUOutM !== e.alu || WriteRegM !== e.wreg) begin
      errors++;
      $display("FAIL flush_m_data got=%h/%0d exp=0/0", ALUOutM, WriteRegM);
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    drive_d(1, 0, 3'b010, 0, 1, 32'h1000, 32'h234, 0, 0, 0, 5'd6);
    sb.push_back('{alu: 32'h1234, wd: 32'h234, wreg: 5'd6, regw: 1, memw: 0});
    step();
    drive_d(1, 1, 3'b010, 0, 1, 32'h1, 32'h1, 0, 0, 0, 5'd9);
    step();
    e = sb.pop_front();
    checks++;
    if (ALUOutM !== e.alu || RegWriteM !== e.regw) begin
      errors++;
      $display("FAIL pre_rst got=%h/%b exp=%h/%b",
               ALUOutM, RegWriteM, e.alu, e.regw);
    end
    #2;
    RST = 1'b0;
    #1;
    checks++;
    if (ALUOutM !== 32'h0 || RegWriteM !== 1'b0) begin
      errors++;
      $display("FAIL async_rst_m got=%h/%b exp=0/0", ALUOutM, RegWriteM);
    end
    checks++;
    if (RegWriteE !== 1'b0 || WriteRegE !== 5'd0) begin
      errors++;
      $display("FAIL async_rst_e got=%b/%0d exp=0/0", RegWriteE, WriteRegE);
    end
    step();
    @(negedge CLK);
    RST = 1'b1;
    drive_nop();
    step();
    checks++;
    if (RegWriteE !== 1'b0 || RegWriteM !== 1'b0) begin
      errors++;
      $display("FAIL rst_discard got=%b/%b exp=0/0", RegWriteE, RegWriteM);
    end
  endtask

  task automatic test_fwd_imm();
    exp_t e;
    drive_d(0, 1, 3'b010, 1, 0, 32'h20, 32'h99, 32'hFFFFFFFC, 0, 5'd3, 0);
    sb.push_back('{alu: 32'h1C, wd: 32'h55, wreg: 5'd3, regw: 0, memw: 1});
    step();
    ForwardBE = 2'b01;
    ResultW = 32'h55;
    drive_d(1, 0, 3'b110, 0, 1, 32'd6, 32'd3, 0, 0, 0, 5'd12);
    sb.push_back('{alu: ref_alu(3'b110, 6, 3), wd: 32'd3,
                   wreg: 5'd12, regw: 1, memw: 0});
    step();
    ForwardBE = 2'b00;
    ForwardAE = 2'b11;
    ResultW = 32'hDEAD;
    drive_nop();
    e = sb.pop_front();
    checks++;
    if (ALUOutM !== e.alu) begin
      errors++;
      $display("FAIL imm_aluout got=%h exp=%h", ALUOutM, e.alu);
    end
    checks++;
    if (WriteDataM !== e.wd || MemWriteM !== e.memw) begin
      errors++;
      $display("FAIL fwdb_wdata got=%h/%b exp=%h/%b",
               WriteDataM, MemWriteM, e.wd, e.memw);
    end
    step();
    ForwardAE = 2'b00;
    e = sb.pop_front();
    checks++;
    if (ALUOutM !== e.alu || WriteRegM !== e.wreg) begin
      errors++;
      $display("FAIL fwd11_as_rf got=%h/%0d exp=%h/%0d",
               ALUOutM, WriteRegM, e.alu, e.wreg);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_slt();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_fwd_imm();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
